axis_bram_loader: RTL and testbench
===================================

# axis_bram_loader

Parametrised AXI4-Stream to BRAM loader, next generation of the fetch unit. Accepts one frame per load over a 32-bit-class AXIS slave and writes each beat into one of `NUM_TARGETS` BRAM write ports. Each frame has its own target select and matrix shape, and can be written linear or transposed. Per-target completion pulses and sticky error flags go to the control plane; processing elements start on `load_done`.

## Interface
Parameters:
- `NUM_TARGETS`, 4: number of BRAM write ports (≥2).
- `SEL_W`, 2: width of the target select; `$clog2(NUM_TARGETS)`.
- `ADDR_W`, 11: BRAM address width, shared by all targets.
- `DATA_W`, 32: stream and BRAM data width.

Ports:
- `S_AXIS_ACLK` in 1: the single clock.
- `S_AXIS_ARESETN` in 1: reset, synchronous and active-low.
- `S_AXIS_TDATA` in `DATA_W`: beat payload.
- `S_AXIS_TVALID` in 1: beat valid.
- `S_AXIS_TLAST` in 1: last beat of frame.
- `S_AXIS_TREADY` out 1: beat accepted when TVALID&TREADY.
- `cfg_sel` in `SEL_W`: target BRAM for the next frame.
- `cfg_transpose` in 1: 1 = column-major write of a row-major stream.
- `cfg_rows` in `ADDR_W`: matrix rows.
- `cfg_cols` in `ADDR_W`: matrix columns.
- `err_clr` in 1: clears sticky error flags.
- `bram_addr` out `ADDR_W`: write address, shared by all targets.
- `bram_din` out `DATA_W`: write data, shared by all targets.
- `bram_we` out `NUM_TARGETS`: one-hot write enable.
- `load_done` out `NUM_TARGETS`: one-cycle pulse on the finished target.
- `load_count` out `ADDR_W+1`: beats written in the last frame.
- `busy` out 1: high in LOAD and DONE.
- `err_overflow` out 1: sticky; frame had more than rows*cols beats.
- `err_short` out 1: sticky; TLAST arrived before rows*cols beats.
- `err_sel` out 1: sticky; `cfg_sel` ≥ `NUM_TARGETS`.

## Operation
State machine, encoded IDLE, LOAD, DONE:
- **IDLE**
  - TREADY=1.
  - First handshake latches `cfg_*` into internal registers. This beat is element 0.
  - Without TLAST, go to LOAD. With TLAST, go to DONE (one-beat frame).
- **LOAD**
  - TREADY=1. Each handshake is element k+1.
  - A TLAST handshake goes to DONE.
  - `cfg_*` changes during LOAD are ignored.
- **DONE**
  - Lasts one cycle with TREADY=0, then returns to IDLE.

Address generation (r, c = row, col counters; element k = r*cols + c in row-major order):
- Linear: addr = k.
- Transpose: addr = c*rows + r.
  - Each beat adds `rows` to addr.
  - When c wraps from cols-1 to 0: addr = r+1 and r increments.
- No multiplier in the address path. The expected count rows*cols is computed once at latch, `2*ADDR_W` wide.

Boundary conditions:
- **Beat index ≥ rows*cols, or ≥ 2^ADDR_W:** the beat is accepted but not written (`bram_we`=0) and sets `err_overflow`. The frame still ends only on TLAST.
- **TLAST with count < rows*cols:** the frame completes normally and sets `err_short`.
- **rows or cols = 0:** every beat overflows.
- **`cfg_sel` out of range:** all beats are accepted and discarded, and `err_sel` is set. `load_done` is all zero for that frame.
- **Error flags:** clear only on reset or `err_clr`. If `err_clr` and a new error event occur in the same cycle, the error wins.
- **Counts:** `load_count` counts written beats only. It updates in DONE and holds until the next DONE.

## Timing
- Handshake in cycle t: `bram_addr`/`bram_din`/`bram_we` are registered and valid in cycle t+1 for exactly one cycle. TVALID gaps produce `bram_we`=0 cycles.
- TLAST handshake in cycle t:
  - Final write happens in cycle t+1.
  - DONE is cycle t+1, with `load_done[sel]`=1 in the same cycle.
  - IDLE with TREADY=1 resumes in cycle t+2.
- Back-to-back frames therefore have exactly one bubble between them.
- Reset values (also on reset mid-frame):
  - State IDLE; all counters 0; `load_count`=0.
  - `bram_we`=0, `bram_addr`=0, `bram_din`=0, `load_done`=0, `busy`=0.
  - All error flags 0. TREADY=0 during reset, 1 from the first cycle after.
- BRAM contents written before a mid-frame reset are not rolled back.

## Structure
- Package `axis_bram_loader_pkg` holds:
  - the state enum;
  - localparam widths derived from `ADDR_W`;
  - a function computing the transpose next address.
- Sub-module `axis_bram_loader_agen` holds the r/c counters, the linear and transpose address registers, and the overflow compare. It exposes advance, restart, shape inputs and an addr/overflow output.
- The top level holds the FSM, config latch, output registers and error flags.

## Test plan
- **Linear load:** sel=0, rows=4, cols=4, 16 beats 0x100..0x10F, TLAST on the 16th. Expect `bram_we`=0001 at addr 0..15 with matching data, one `load_done`=0001 pulse, `load_count`=16, no errors.
- **Transpose:** sel=1, rows=3, cols=4, 12 beats. Expect address sequence 0,3,6,9,1,4,7,10,2,5,8,11, `bram_we`=0010 throughout, and `load_done`[1] in the cycle after the last handshake.
- **Backpressure and gaps:** random TVALID gaps on a 2x2 linear frame. Each write occurs exactly 1 cycle after its handshake. A second frame sent immediately sees TREADY=0 for exactly one cycle.
- **Overflow and short frames:**
  - rows=2, cols=2 with 6 beats: writes at addr 0..3 only, `err_overflow`=1, `load_count`=4.
  - Next frame, 3 beats: `err_short`=1 and `err_overflow` still 1.
  - `err_clr` clears both.
- **Bad select:** with `NUM_TARGETS`=3 and sel=3, a 4-beat frame gives `bram_we`=0 throughout, `err_sel`=1 and `load_done`=0.
- **Reset mid-frame:** assert reset after beat 5 of a 16-beat frame. All outputs read 0 next cycle. A following 4-beat frame writes from addr 0.

Source files
------------

// File: rtl/axis_bram_loader_pkg.sv
// Shared types and helpers for the AXIS-to-BRAM loader.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axis_bram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest address the transpose helper is built for; real ports truncate.
  localparam int unsigned AGEN_MAX_W = 32;

  typedef logic [AGEN_MAX_W-1:0] wide_addr_t;

  // Beat counter width: one extra bit so 2^ADDR_W beats can be represented.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

  // Expected beat count rows*cols needs the full product width.
  function automatic int exp_w(input int addr_w);
    return 2 * addr_w;
  endfunction

  // Column-major walk of a row-major stream: step by one row-stride per
  // beat, and restart at the next row index when the column wraps.
  function automatic wide_addr_t tr_next_addr(input wide_addr_t cur_addr,
                                              input wide_addr_t cur_row,
                                              input wide_addr_t rows,
                                              input logic       col_wrap);
    return col_wrap ? (cur_row + wide_addr_t'(1)) : (cur_addr + rows);
  endfunction

endpackage

// File: rtl/axis_bram_loader_agen.sv
// Address generator: row/col counters, linear and transposed addresses, overflow flag.
// Latency: addr/ovf are combinational for the current beat; state advances on advance_i.
// Backpressure: none; it only steps when the parent reports an accepted beat.
module axis_bram_loader_agen
  import axis_bram_loader_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                restart_i,
  input  logic                advance_i,
  input  logic                transpose_i,
  input  logic [ADDR_W-1:0]   rows_i,
  input  logic [ADDR_W-1:0]   cols_i,
  input  logic [2*ADDR_W-1:0] expect_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [ADDR_W:0]     idx_o,
  output logic                ovf_o
);

  localparam int CNT_W = cnt_w(ADDR_W);
  localparam int EXP_W = exp_w(ADDR_W);

  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic [ADDR_W-1:0] tr_q, tr_d;
  logic [CNT_W-1:0]  idx_q, idx_d;

  logic [ADDR_W-1:0] cur_row, cur_col, cur_lin, cur_tr;
  logic [CNT_W-1:0]  cur_idx;
  logic              col_wrap;

  // Current element position; a restart makes this beat element 0 regardless of stale state.
  always_comb begin
    cur_row  = restart_i ? '0 : row_q;
    cur_col  = restart_i ? '0 : col_q;
    cur_lin  = restart_i ? '0 : lin_q;
    cur_tr   = restart_i ? '0 : tr_q;
    cur_idx  = restart_i ? '0 : idx_q;
    col_wrap = (cur_col == (cols_i - ADDR_W'(1)));

    row_d = col_wrap ? (cur_row + ADDR_W'(1)) : cur_row;
    col_d = col_wrap ? '0 : (cur_col + ADDR_W'(1));
    lin_d = cur_lin + ADDR_W'(1);
    tr_d  = ADDR_W'(tr_next_addr(wide_addr_t'(cur_tr), wide_addr_t'(cur_row),
                                 wide_addr_t'(rows_i), col_wrap));
    // Saturate at 2^ADDR_W so long frames keep reporting overflow.
    idx_d = cur_idx[ADDR_W] ? cur_idx : (cur_idx + CNT_W'(1));

    addr_o = transpose_i ? cur_tr : cur_lin;
    idx_o  = cur_idx;
    ovf_o  = cur_idx[ADDR_W] | (EXP_W'(cur_idx) >= expect_i);
  end

  // Step the position registers once per accepted beat.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
      lin_q <= '0;
      tr_q  <= '0;
      idx_q <= '0;
    end else if (advance_i) begin
      row_q <= row_d;
      col_q <= col_d;
      lin_q <= lin_d;
      tr_q  <= tr_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/axis_bram_loader.sv
// AXI4-Stream slave that writes one frame per load into one of NUM_TARGETS BRAM ports.
// Latency: write 1 cycle after each handshake; load_done in the cycle after TLAST.
// Backpressure: TREADY is high in IDLE/LOAD and low for the single DONE cycle (and in reset).
module axis_bram_loader
  import axis_bram_loader_pkg::*;
#(
  parameter int NUM_TARGETS = 4,
  parameter int SEL_W       = 2,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32
) (
  input  logic                   S_AXIS_ACLK,
  input  logic                   S_AXIS_ARESETN,
  input  logic [DATA_W-1:0]      S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  input  logic [SEL_W-1:0]       cfg_sel,
  input  logic                   cfg_transpose,
  input  logic [ADDR_W-1:0]      cfg_rows,
  input  logic [ADDR_W-1:0]      cfg_cols,
  input  logic                   err_clr,
  output logic [ADDR_W-1:0]      bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  output logic [NUM_TARGETS-1:0] bram_we,
  output logic [NUM_TARGETS-1:0] load_done,
  output logic [ADDR_W:0]        load_count,
  output logic                   busy,
  output logic                   err_overflow,
  output logic                   err_short,
  output logic                   err_sel
);

  localparam int CNT_W = cnt_w(ADDR_W);
  localparam int EXP_W = exp_w(ADDR_W);
  localparam logic [NUM_TARGETS-1:0] ONE_HOT0 = NUM_TARGETS'(1);

  state_e state_q, state_d;

  // Frame configuration captured on the first beat.
  logic [SEL_W-1:0]  sel_q;
  logic              sel_ok_q;
  logic              transpose_q;
  logic [ADDR_W-1:0] rows_q, cols_q;
  logic [EXP_W-1:0]  exp_q;

  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      din_q;
  logic [NUM_TARGETS-1:0] we_q, done_q;
  logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]       load_count_q;
  logic                   err_ovf_q, err_short_q, err_sel_q;

  logic                   tready, hs, last_hs, restart, latch;
  logic [EXP_W-1:0]       exp_in, exp_eff;
  logic                   sel_ok_in, sel_ok_eff, tr_eff;
  logic [SEL_W-1:0]       sel_eff;
  logic [ADDR_W-1:0]      rows_eff, cols_eff;
  logic [NUM_TARGETS-1:0] sel_onehot;
  logic [ADDR_W-1:0]      agen_addr;
  logic [ADDR_W:0]        agen_idx;
  logic                   agen_ovf, wr_now, short_now;

  assign tready  = S_AXIS_ARESETN && (state_q != ST_DONE);
  assign hs      = S_AXIS_TVALID && tready;
  assign last_hs = hs && S_AXIS_TLAST;
  assign restart = (state_q == ST_IDLE);
  assign latch   = hs && restart;

  // In IDLE the incoming beat is element 0 and must use the live config;
  // afterwards the latched copy is used so mid-frame cfg changes are ignored.
  assign exp_in     = EXP_W'(cfg_rows) * EXP_W'(cfg_cols);
  assign sel_ok_in  = 32'(cfg_sel) < 32'(NUM_TARGETS);
  assign sel_eff    = restart ? cfg_sel       : sel_q;
  assign sel_ok_eff = restart ? sel_ok_in     : sel_ok_q;
  assign tr_eff     = restart ? cfg_transpose : transpose_q;
  assign rows_eff   = restart ? cfg_rows      : rows_q;
  assign cols_eff   = restart ? cfg_cols      : cols_q;
  assign exp_eff    = restart ? exp_in        : exp_q;
  assign sel_onehot = ONE_HOT0 << sel_eff;

  axis_bram_loader_agen #(
    .ADDR_W(ADDR_W)
  ) u_agen (
    .clk_i      (S_AXIS_ACLK),
    .rst_ni     (S_AXIS_ARESETN),
    .restart_i  (restart),
    .advance_i  (hs),
    .transpose_i(tr_eff),
    .rows_i     (rows_eff),
    .cols_i     (cols_eff),
    .expect_i   (exp_eff),
    .addr_o     (agen_addr),
    .idx_o      (agen_idx),
    .ovf_o      (agen_ovf)
  );

  assign wr_now    = hs && sel_ok_eff && !agen_ovf;
  assign wr_cnt_d  = (restart ? '0 : wr_cnt_q) + CNT_W'(wr_now);
  assign short_now = last_hs && ((EXP_W'(agen_idx) + EXP_W'(1)) < exp_eff);

  // Next-state logic: IDLE -> LOAD/DONE on first beat, LOAD -> DONE on TLAST, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hs) state_d = S_AXIS_TLAST ? ST_DONE : ST_LOAD;
      ST_LOAD: if (last_hs) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Capture frame configuration on the first accepted beat.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      sel_q       <= '0;
      sel_ok_q    <= 1'b0;
      transpose_q <= 1'b0;
      rows_q      <= '0;
      cols_q      <= '0;
      exp_q       <= '0;
    end else if (latch) begin
      sel_q       <= cfg_sel;
      sel_ok_q    <= sel_ok_in;
      transpose_q <= cfg_transpose;
      rows_q      <= cfg_rows;
      cols_q      <= cfg_cols;
      exp_q       <= exp_in;
    end
  end

  // Registered BRAM write port, completion pulse and written-beat counters.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= '0;
      done_q       <= '0;
      wr_cnt_q     <= '0;
      load_count_q <= '0;
    end else begin
      we_q   <= wr_now ? sel_onehot : '0;
      done_q <= (last_hs && sel_ok_eff) ? sel_onehot : '0;
      if (hs) begin
        addr_q   <= agen_addr;
        din_q    <= S_AXIS_TDATA;
        wr_cnt_q <= wr_cnt_d;
      end
      if (last_hs) load_count_q <= wr_cnt_d;
    end
  end

  // Sticky error flags; a new event beats a simultaneous clear.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      err_ovf_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_sel_q   <= 1'b0;
    end else begin
      err_ovf_q   <= (hs && agen_ovf)       || (err_ovf_q   && !err_clr);
      err_short_q <= short_now              || (err_short_q && !err_clr);
      err_sel_q   <= (latch && !sel_ok_in)  || (err_sel_q   && !err_clr);
    end
  end

  assign S_AXIS_TREADY = tready;
  assign bram_addr     = addr_q;
  assign bram_din      = din_q;
  assign bram_we       = we_q;
  assign load_done     = done_q;
  assign load_count    = load_count_q;
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign err_overflow  = err_ovf_q;
  assign err_short     = err_short_q;
  assign err_sel       = err_sel_q;

endmodule

// File: tb/tb_axis_bram_loader.sv
// Directed bench for axis_bram_loader with three targets (sel=3 is out of range).
// Inputs driven on the falling edge; outputs logged and checked on the falling edge.
module tb_axis_bram_loader;

  localparam int NT = 3;
  localparam int SW = 2;
  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tready;
  logic [SW-1:0] cfg_sel;
  logic          cfg_transpose;
  logic [AW-1:0] cfg_rows, cfg_cols;
  logic          err_clr;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [NT-1:0] bram_we, load_done;
  logic [AW:0]   load_count;
  logic          busy, err_overflow, err_short, err_sel;

  always #5 clk = ~clk;

  axis_bram_loader #(
    .NUM_TARGETS(NT), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .cfg_sel       (cfg_sel),
    .cfg_transpose (cfg_transpose),
    .cfg_rows      (cfg_rows),
    .cfg_cols      (cfg_cols),
    .err_clr       (err_clr),
    .bram_addr     (bram_addr),
    .bram_din      (bram_din),
    .bram_we       (bram_we),
    .load_done     (load_done),
    .load_count    (load_count),
    .busy          (busy),
    .err_overflow  (err_overflow),
    .err_short     (err_short),
    .err_sel       (err_sel)
  );

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NT-1:0] we;
  } wr_t;

  int            cyc = 0;
  wr_t           wr_q[$];
  int            done_c[$];
  logic [NT-1:0] done_v[$];
  logic          done_b[$];
  int            hs_q[$];
  int            exp_a[$];
  int            n_vec = 0;
  int            n_miss = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write and every completion pulse with its cycle number.
  always @(negedge clk) begin
    wr_t w;
    if (|bram_we) begin
      w.c = cyc; w.a = bram_addr; w.d = bram_din; w.we = bram_we;
      wr_q.push_back(w);
    end
    if (|load_done) begin
      done_c.push_back(cyc);
      done_v.push_back(load_done);
      done_b.push_back(busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete(); done_c.delete(); done_v.delete(); done_b.delete();
    hs_q.delete(); exp_a.delete();
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present one beat from a falling edge and hold it until accepted.
  task automatic send(input logic [DW-1:0] d, input logic last);
    bit got = 0;
    tvalid = 1'b1; tdata = d; tlast = last;
    for (int w = 0; w < 20 && !got; w++) begin
      #1;
      if (tready) begin
        hs_q.push_back(cyc);
        got = 1;
      end
      @(negedge clk);
    end
    chk("hs_timeout", 64'(got), 64'd1);
    tvalid = 1'b0;
  endtask

  // Send a whole frame; cfg is scrambled after beat 0 to prove it is latched.
  task automatic send_frame(input logic [SW-1:0] sel, input logic tr,
                            input int rows, input int cols, input int n,
                            input logic [DW-1:0] base, input int gap_max);
    cfg_sel = sel; cfg_transpose = tr;
    cfg_rows = AW'(rows); cfg_cols = AW'(cols);
    for (int i = 0; i < n; i++) begin
      send(base + DW'(i), i == n - 1);
      if (i == 0) begin
        cfg_sel = sel ^ SW'(1); cfg_transpose = ~tr;
        cfg_rows = AW'(rows + 3); cfg_cols = AW'(cols + 1);
      end
      if (i != n - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  // Compare logged writes against exp_a; data for write i is base+i.
  task automatic check_writes(input string tag, input logic [NT-1:0] we, input logic [DW-1:0] base);
    int n;
    chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_a.size()));
    n = (wr_q.size() < exp_a.size()) ? wr_q.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_q[i].a), 64'(exp_a[i]));
      chk($sformatf("%s_din%0d", tag, i), 64'(wr_q[i].d), 64'(base + DW'(i)));
      chk($sformatf("%s_we%0d", tag, i), 64'(wr_q[i].we), 64'(we));
      if (i < hs_q.size())
        chk($sformatf("%s_lat%0d", tag, i), 64'(wr_q[i].c), 64'(hs_q[i] + 1));
    end
  endtask

  task automatic check_done(input string tag, input logic [NT-1:0] v);
    chk({tag, "_ndone"}, 64'(done_c.size()), 64'd1);
    if (done_c.size() > 0 && hs_q.size() > 0) begin
      chk({tag, "_done_v"}, 64'(done_v[0]), 64'(v));
      chk({tag, "_done_cyc"}, 64'(done_c[0]), 64'(hs_q[hs_q.size() - 1] + 1));
      chk({tag, "_done_busy"}, 64'(done_b[0]), 64'd1);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 64'(bram_we), 64'd0);
    chk({tag, "_addr"}, 64'(bram_addr), 64'd0);
    chk({tag, "_din"}, 64'(bram_din), 64'd0);
    chk({tag, "_done"}, 64'(load_done), 64'd0);
    chk({tag, "_cnt"}, 64'(load_count), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_errs"}, 64'({err_overflow, err_short, err_sel}), 64'd0);
    chk({tag, "_rdy"}, 64'(tready), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
    cfg_sel = '0; cfg_transpose = 1'b0; cfg_rows = '0; cfg_cols = '0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("rst_rdy_after", 64'(tready), 64'd1);

    // Linear 4x4 into target 0.
    clear_logs();
    for (int i = 0; i < 16; i++) exp_a.push_back(i);
    send_frame(2'd0, 1'b0, 4, 4, 16, 32'h100, 0);
    idle(4);
    check_writes("lin", 3'b001, 32'h100);
    check_done("lin", 3'b001);
    chk("lin_cnt", 64'(load_count), 64'd16);
    chk("lin_errs", 64'({err_overflow, err_short, err_sel}), 64'd0);
    chk("lin_busy_idle", 64'(busy), 64'd0);

    // Transposed 3x4 into target 1.
    clear_logs();
    exp_a = '{0, 3, 6, 9, 1, 4, 7, 10, 2, 5, 8, 11};
    send_frame(2'd1, 1'b1, 3, 4, 12, 32'h200, 0);
    idle(4);
    check_writes("tr", 3'b010, 32'h200);
    check_done("tr", 3'b010);
    chk("tr_cnt", 64'(load_count), 64'd12);

    // 2x2 linear with TVALID gaps, then a second frame right behind it.
    clear_logs();
    exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
    send_frame(2'd2, 1'b0, 2, 2, 4, 32'h300, 3);
    send_frame(2'd2, 1'b0, 2, 2, 4, 32'h304, 0);
    idle(4);
    check_writes("gap", 3'b100, 32'h300);
    chk("gap_nhs", 64'(hs_q.size()), 64'd8);
    if (hs_q.size() >= 5) chk("gap_bubble", 64'(hs_q[4] - hs_q[3]), 64'd2);
    chk("gap_ndone", 64'(done_c.size()), 64'd2);

    // Overflow: 6 beats into a 2x2 frame.
    clear_logs();
    exp_a = '{0, 1, 2, 3};
    send_frame(2'd0, 1'b0, 2, 2, 6, 32'h400, 0);
    idle(3);
    check_writes("ovf", 3'b001, 32'h400);
    chk("ovf_flag", 64'(err_overflow), 64'd1);
    chk("ovf_short", 64'(err_short), 64'd0);
    chk("ovf_cnt", 64'(load_count), 64'd4);

    // Short: 3 beats into a 2x2 frame; overflow stays sticky.
    clear_logs();
    exp_a = '{0, 1, 2};
    send_frame(2'd0, 1'b0, 2, 2, 3, 32'h500, 0);
    idle(3);
    check_writes("short", 3'b001, 32'h500);
    chk("short_flag", 64'(err_short), 64'd1);
    chk("short_ovf_sticky", 64'(err_overflow), 64'd1);
    chk("short_cnt", 64'(load_count), 64'd3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1 chk("clr_flags", 64'({err_overflow, err_short}), 64'd0);

    // Out-of-range select: beats swallowed, no completion pulse.
    clear_logs();
    send_frame(2'd3, 1'b0, 2, 2, 4, 32'h600, 0);
    idle(3);
    check_writes("bsel", 3'b000, 32'h600);
    chk("bsel_ndone", 64'(done_c.size()), 64'd0);
    chk("bsel_flag", 64'(err_sel), 64'd1);
    chk("bsel_cnt", 64'(load_count), 64'd0);
    chk("bsel_ovf", 64'(err_overflow), 64'd0);

    // Reset after 5 beats of a 4x4 frame.
    clear_logs();
    cfg_sel = 2'd0; cfg_transpose = 1'b0; cfg_rows = 11'd4; cfg_cols = 11'd4;
    for (int i = 0; i < 5; i++) send(32'h700 + DW'(i), 1'b0);
    chk("mid_addr_before", 64'(bram_addr), 64'd4);
    rst_n = 1'b0;
    @(negedge clk);
    #1 check_zero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("midrst_rdy_after", 64'(tready), 64'd1);
    clear_logs();
    exp_a = '{0, 1, 2, 3};
    send_frame(2'd1, 1'b0, 2, 2, 4, 32'h800, 0);
    idle(3);
    check_writes("post", 3'b010, 32'h800);
    check_done("post", 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
